// File: rtl/peri_arb_pkg.sv
// Shared types and constants for the two-master peripheral register arbiter.
package peri_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  localparam logic [31:0] ARB_ERR_DATA = 32'hDEAD_DEAD;

  localparam logic ARB_RR    = 1'b0;
  localparam logic ARB_FIXED = 1'b1;

endpackage

// File: rtl/peri_reg_arb.sv
// Two-master arbiter for the peripheral register slave port: one transaction
// at a time, round-robin or fixed priority, with a bounded ack timeout.
module peri_reg_arb
  import peri_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int ADDR_W      = 11
) (
  input  logic              mclk,
  input  logic              s_reset_n,
  input  logic              cfg_arb_mode,

  input  logic              m0_cs,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_be,
  output logic [31:0]       m0_rdata,
  output logic              m0_ack,
  output logic              m0_err,

  input  logic              m1_cs,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_be,
  output logic [31:0]       m1_rdata,
  output logic              m1_ack,
  output logic              m1_err,

  output logic              reg_cs,
  output logic              reg_wr,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [31:0]       reg_wdata,
  output logic [3:0]        reg_be,
  input  logic [31:0]       reg_rdata,
  input  logic              reg_ack,

  output logic              arb_timeout
);

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYC);

  // Returns the winning master index (0 or 1); only meaningful when a request is present.
  function automatic logic pick_winner(input logic mode, input logic cs0,
                                       input logic cs1, input logic last);
    if (mode == ARB_FIXED) return !cs0;
    if (cs0 && cs1)        return !last;
    return !cs0;
  endfunction

  arb_state_e        r_state;
  logic [7:0]        r_cnt;
  logic              r_gnt;
  logic              r_last_gnt;
  logic              r_reg_cs;
  logic              r_reg_wr;
  logic [ADDR_W-1:0] r_reg_addr;
  logic [31:0]       r_reg_wdata;
  logic [3:0]        r_reg_be;
  logic              r_m0_ack, r_m1_ack;
  logic              r_m0_err, r_m1_err;
  logic [31:0]       r_m0_rdata, r_m1_rdata;
  logic              r_timeout;

  logic              w_any_req;
  logic              w_winner;
  logic              w_ack_now;
  logic              w_expire;
  logic [31:0]       w_resp_data;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_any_req   = m0_cs | m1_cs;
    w_winner    = pick_winner(cfg_arb_mode, m0_cs, m1_cs, r_last_gnt);
    w_ack_now   = (r_state == GRANT) && reg_ack;
    w_expire    = (r_state == GRANT) && !reg_ack && (r_cnt == TO_LIMIT);
    w_resp_data = reg_ack ? reg_rdata : ARB_ERR_DATA;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge mclk or negedge s_reset_n) begin
    if (!s_reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_gnt       <= 1'b0;
      r_last_gnt  <= 1'b1;
      r_reg_cs    <= 1'b0;
      r_reg_wr    <= 1'b0;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
      r_reg_be    <= '0;
      r_m0_ack    <= 1'b0;
      r_m1_ack    <= 1'b0;
      r_m0_err    <= 1'b0;
      r_m1_err    <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
      r_timeout   <= 1'b0;
    end else begin
      // Master responses are single-cycle pulses; they are only raised on GRANT exit.
      r_m0_ack   <= 1'b0;
      r_m1_ack   <= 1'b0;
      r_m0_err   <= 1'b0;
      r_m1_err   <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
      r_timeout  <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_gnt       <= w_winner;
            r_last_gnt  <= w_winner;
            r_cnt       <= '0;
            r_reg_cs    <= 1'b1;
            r_reg_wr    <= w_winner ? m1_wr    : m0_wr;
            r_reg_addr  <= w_winner ? m1_addr  : m0_addr;
            r_reg_wdata <= w_winner ? m1_wdata : m0_wdata;
            r_reg_be    <= w_winner ? m1_be    : m0_be;
            r_state     <= GRANT;
          end
        end

        GRANT: begin
          // An ack in the expiry cycle wins: w_expire already excludes reg_ack.
          if (w_ack_now || w_expire) begin
            r_reg_cs  <= 1'b0;
            r_timeout <= w_expire;
            if (r_gnt) begin
              r_m1_ack   <= 1'b1;
              r_m1_err   <= w_expire;
              r_m1_rdata <= w_resp_data;
            end else begin
              r_m0_ack   <= 1'b1;
              r_m0_err   <= w_expire;
              r_m0_rdata <= w_resp_data;
            end
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign reg_cs      = r_reg_cs;
  assign reg_wr      = r_reg_wr;
  assign reg_addr    = r_reg_addr;
  assign reg_wdata   = r_reg_wdata;
  assign reg_be      = r_reg_be;
  assign m0_ack      = r_m0_ack;
  assign m0_err      = r_m0_err;
  assign m0_rdata    = r_m0_rdata;
  assign m1_ack      = r_m1_ack;
  assign m1_err      = r_m1_err;
  assign m1_rdata    = r_m1_rdata;
  assign arb_timeout = r_timeout;

endmodule

// File: tb/tb_peri_reg_arb.sv
// Directed, table-driven bench for peri_reg_arb with TIMEOUT_CYC = 4, plus
// hand-written sequences for IDLE ack, protocol violation and mid-GRANT reset.
module tb_peri_reg_arb;

  localparam int TB_TIMEOUT = 4;
  localparam int AW         = 11;

  logic          mclk;
  logic          s_reset_n;
  logic          cfg_arb_mode;
  logic          m0_cs, m0_wr, m1_cs, m1_wr;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [31:0]   m0_wdata, m1_wdata;
  logic [3:0]    m0_be, m1_be;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          m0_ack, m0_err, m1_ack, m1_err;
  logic          reg_cs, reg_wr;
  logic [AW-1:0] reg_addr;
  logic [31:0]   reg_wdata;
  logic [3:0]    reg_be;
  logic [31:0]   reg_rdata;
  logic          reg_ack;
  logic          arb_timeout;

  int checks = 0;
  int errors = 0;

  peri_reg_arb #(.TIMEOUT_CYC(TB_TIMEOUT), .ADDR_W(AW)) dut (
    .mclk(mclk), .s_reset_n(s_reset_n), .cfg_arb_mode(cfg_arb_mode),
    .m0_cs(m0_cs), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cs(m1_cs), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .reg_cs(reg_cs), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_be(reg_be), .reg_rdata(reg_rdata), .reg_ack(reg_ack),
    .arb_timeout(arb_timeout)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          mode;
    logic          cs0, cs1;
    logic          wr0, wr1;
    logic [AW-1:0] addr0, addr1;
    logic [31:0]   wdata0, wdata1;
    logic [31:0]   slv_rdata;
    int            ack_at;     // GRANT cycle (1-based) in which the slave acks; 0 = never
    logic          exp_gnt;
    logic          exp_err;
    logic [31:0]   exp_rdata;
    int            exp_to;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic mode, input logic cs0, input logic cs1,
                              input logic wr0, input logic wr1,
                              input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                              input logic [31:0] srd, input int ack_at,
                              input logic eg, input logic ee,
                              input logic [31:0] erd, input int eto);
    vec_t v;
    v.mode = mode; v.cs0 = cs0; v.cs1 = cs1; v.wr0 = wr0; v.wr1 = wr1;
    v.addr0 = a0; v.addr1 = a1;
    v.wdata0 = 32'hA0A0_0000 | 32'(a0);
    v.wdata1 = 32'hB1B1_0000 | 32'(a1);
    v.slv_rdata = srd; v.ack_at = ack_at;
    v.exp_gnt = eg; v.exp_err = ee; v.exp_rdata = erd; v.exp_to = eto;
    return v;
  endfunction

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  // Runs one transaction starting in an IDLE cycle; returns in the IDLE cycle after RESP.
  task automatic run_row(input vec_t v, input int idx);
    int   first_cs = -1;
    int   ack_cyc  = -1;
    int   cs_cyc   = 0;
    int   to_cnt   = 0;
    logic done     = 1'b0;
    logic dirty    = 1'b0;
    logic unstable = 1'b0;
    logic [1:0]    acks = 2'b00;
    logic [31:0]   got_rdata = '0;
    logic          got_err = 1'b0;
    logic          f_wr = 1'b0;
    logic [AW-1:0] f_addr = '0;
    logic [31:0]   f_wdata = '0;
    logic [3:0]    f_be = '0;
    logic [AW-1:0] e_addr;
    int            e_lat;
    string         p;

    p = $sformatf("row%0d", idx);
    cfg_arb_mode = v.mode;
    m0_cs = v.cs0; m0_wr = v.wr0; m0_addr = v.addr0; m0_wdata = v.wdata0; m0_be = 4'h3;
    m1_cs = v.cs1; m1_wr = v.wr1; m1_addr = v.addr1; m1_wdata = v.wdata1; m1_be = 4'hC;
    reg_rdata = v.slv_rdata;
    reg_ack = 1'b0;

    for (int c = 0; c < 300 && !done; c++) begin
      step();
      if (v.exp_gnt) dirty = dirty | m0_ack | m0_err | (|m0_rdata);
      else           dirty = dirty | m1_ack | m1_err | (|m1_rdata);
      if (arb_timeout) to_cnt++;
      if (reg_cs) begin
        cs_cyc++;
        if (first_cs < 0) begin
          first_cs = c;
          f_wr = reg_wr; f_addr = reg_addr; f_wdata = reg_wdata; f_be = reg_be;
        end else if (reg_wr !== f_wr || reg_addr !== f_addr ||
                     reg_wdata !== f_wdata || reg_be !== f_be) begin
          unstable = 1'b1;
        end
        reg_ack = (cs_cyc == v.ack_at);
      end else begin
        reg_ack = 1'b0;
      end
      if (m0_ack || m1_ack) begin
        done = 1'b1;
        ack_cyc = c;
        acks = {m1_ack, m0_ack};
        got_rdata = v.exp_gnt ? m1_rdata : m0_rdata;
        got_err   = v.exp_gnt ? m1_err   : m0_err;
        check({p, "_reg_cs_low_in_resp"}, 32'(reg_cs), 32'd0);
        m0_cs = 1'b0;
        m1_cs = 1'b0;
        reg_ack = 1'b0;
      end
    end

    e_addr = v.exp_gnt ? v.addr1 : v.addr0;
    e_lat  = (v.ack_at != 0) ? v.ack_at : TB_TIMEOUT + 1;
    check({p, "_done"},      32'(done), 32'd1);
    check({p, "_ack_who"},   32'(acks), v.exp_gnt ? 32'd2 : 32'd1);
    check({p, "_rdata"},     got_rdata, v.exp_rdata);
    check({p, "_err"},       32'(got_err), 32'(v.exp_err));
    check({p, "_other_clean"}, 32'(dirty), 32'd0);
    check({p, "_reg_addr"},  32'(f_addr), 32'(e_addr));
    check({p, "_reg_wr"},    32'(f_wr), 32'(v.exp_gnt ? v.wr1 : v.wr0));
    check({p, "_reg_wdata"}, f_wdata, v.exp_gnt ? v.wdata1 : v.wdata0);
    check({p, "_reg_be"},    32'(f_be), v.exp_gnt ? 32'hC : 32'h3);
    check({p, "_stable"},    32'(unstable), 32'd0);
    check({p, "_first_cs"},  32'(first_cs), 32'd0);
    check({p, "_latency"},   32'(ack_cyc - first_cs), 32'(e_lat));
    check({p, "_cs_cycles"}, 32'(cs_cyc), 32'(e_lat));
    check({p, "_timeouts"},  32'(to_cnt), 32'(v.exp_to));
    step();
  endtask

  initial begin
    s_reset_n = 1'b0;
    cfg_arb_mode = 1'b0;
    m0_cs = 0; m0_wr = 0; m0_addr = '0; m0_wdata = '0; m0_be = '0;
    m1_cs = 0; m1_wr = 0; m1_addr = '0; m1_wdata = '0; m1_be = '0;
    reg_rdata = '0; reg_ack = 1'b0;

    //           mode cs0 cs1 wr0 wr1 addr0    addr1    slave rdata   ack gnt err exp rdata     to
    vecs[0]  = mk(1'b0, 1, 1, 1, 0, 11'h010, 11'h020, 32'h1111_0000, 1, 0, 0, 32'h1111_0000, 0);
    vecs[1]  = mk(1'b0, 1, 1, 0, 1, 11'h011, 11'h021, 32'h2222_0000, 1, 1, 0, 32'h2222_0000, 0);
    vecs[2]  = mk(1'b0, 1, 1, 0, 0, 11'h012, 11'h022, 32'h3333_0000, 3, 0, 0, 32'h3333_0000, 0);
    vecs[3]  = mk(1'b0, 1, 1, 1, 1, 11'h013, 11'h023, 32'h4444_0000, 2, 1, 0, 32'h4444_0000, 0);
    vecs[4]  = mk(1'b0, 1, 0, 0, 0, 11'h100, 11'h000, 32'h1234_5678, 2, 0, 0, 32'h1234_5678, 0);
    vecs[5]  = mk(1'b1, 1, 1, 0, 0, 11'h200, 11'h300, 32'h5555_0000, 1, 0, 0, 32'h5555_0000, 0);
    vecs[6]  = mk(1'b1, 1, 1, 1, 0, 11'h201, 11'h301, 32'h6666_0000, 1, 0, 0, 32'h6666_0000, 0);
    vecs[7]  = mk(1'b1, 0, 1, 0, 1, 11'h202, 11'h302, 32'h7777_0000, 2, 1, 0, 32'h7777_0000, 0);
    vecs[8]  = mk(1'b1, 1, 1, 0, 0, 11'h203, 11'h303, 32'h8888_0000, 1, 0, 0, 32'h8888_0000, 0);
    vecs[9]  = mk(1'b0, 0, 1, 0, 0, 11'h000, 11'h7FF, 32'h9999_0000, 0, 1, 1, 32'hDEAD_DEAD, 1);
    vecs[10] = mk(1'b0, 1, 0, 0, 0, 11'h555, 11'h000, 32'hABCD_0123, 5, 0, 0, 32'hABCD_0123, 0);
    vecs[11] = mk(1'b0, 1, 1, 0, 0, 11'h0F0, 11'h70F, 32'h0BAD_F00D, 4, 1, 0, 32'h0BAD_F00D, 0);

    step();
    step();
    check("rst_reg_cs",     32'(reg_cs), 32'd0);
    check("rst_reg_wr",     32'(reg_wr), 32'd0);
    check("rst_reg_addr",   32'(reg_addr), 32'd0);
    check("rst_reg_wdata",  reg_wdata, 32'd0);
    check("rst_reg_be",     32'(reg_be), 32'd0);
    check("rst_acks",       32'({m1_ack, m0_ack}), 32'd0);
    check("rst_errs",       32'({m1_err, m0_err}), 32'd0);
    check("rst_rdata",      m0_rdata | m1_rdata, 32'd0);
    check("rst_timeout",    32'(arb_timeout), 32'd0);
    s_reset_n = 1'b1;
    step();

    for (int i = 0; i < 12; i++) run_row(vecs[i], i);

    // Slave ack while IDLE must be ignored.
    reg_ack = 1'b1;
    step();
    reg_ack = 1'b0;
    check("idle_ack_cs",   32'(reg_cs), 32'd0);
    check("idle_ack_acks", 32'({m1_ack, m0_ack, arb_timeout}), 32'd0);
    step();
    check("idle_ack_acks2", 32'({m1_ack, m0_ack, reg_cs}), 32'd0);

    // Granted master drops cs and changes its address mid-GRANT; mode flips too.
    cfg_arb_mode = 1'b0;
    m0_cs = 1'b1; m0_wr = 1'b0; m0_addr = 11'h0AA; m0_wdata = 32'h0; m0_be = 4'hF;
    reg_rdata = 32'hCAFE_0001;
    step();
    check("viol_cs_up",    32'(reg_cs), 32'd1);
    m0_cs = 1'b0; m0_addr = 11'h155; m0_wr = 1'b1; cfg_arb_mode = 1'b1;
    step();
    check("viol_addr_held", 32'(reg_addr), 32'h0AA);
    check("viol_wr_held",   32'(reg_wr), 32'd0);
    reg_ack = 1'b1;
    step();
    reg_ack = 1'b0;
    check("viol_ack",   32'(m0_ack), 32'd1);
    check("viol_rdata", m0_rdata, 32'hCAFE_0001);
    step();

    // Reset during GRANT of master 0: reg_cs drops at once, no ack, last_gnt back to 1.
    cfg_arb_mode = 1'b0;
    m0_cs = 1'b1; m0_addr = 11'h033;
    step();
    check("rstg_cs_up", 32'(reg_cs), 32'd1);
    #2;
    s_reset_n = 1'b0;
    #1;
    check("rstg_cs_async", 32'(reg_cs), 32'd0);
    check("rstg_no_ack",   32'({m1_ack, m0_ack}), 32'd0);
    m0_cs = 1'b0;
    step();
    check("rstg_held_no_ack", 32'({m1_ack, m0_ack, reg_cs}), 32'd0);
    s_reset_n = 1'b1;
    step();
    run_row(mk(1'b0, 1, 1, 0, 0, 11'h044, 11'h055, 32'hFEED_0000, 1, 0, 0, 32'hFEED_0000, 0), 12);
    run_row(mk(1'b0, 0, 1, 0, 0, 11'h000, 11'h066, 32'hFEED_0001, 1, 1, 0, 32'hFEED_0001, 0), 13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
